// File: rtl/tlc_sensor_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tlc_sensor_conditioner: sync, debounce and latch loop-detector requests. |
// | Optional stuck-sensor flags when TLC_SENSOR_STUCK_EN is defined. Rev 1.0 |
// +--------------------------------------------------------------------------+

module tlc_sensor_conditioner #(
  parameter int DEB_CYCLES = 4
`ifdef TLC_SENSOR_STUCK_EN
  ,
  parameter int STUCK_CYCLES = 1024
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_ew,
  input  logic       raw_lt,
  input  logic       raw_ns,
  input  logic [1:0] dir,
  input  logic       ok,
  output logic       car_ew,
  output logic       car_lt,
  output logic       car_ns
`ifdef TLC_SENSOR_STUCK_EN
  ,
  output logic [2:0] stuck
`endif
);

  localparam int                 c_cnt_w    = $clog2(DEB_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);
`ifdef TLC_SENSOR_STUCK_EN
  localparam int                 c_stk_w    = $clog2(STUCK_CYCLES + 1);
  localparam logic [c_stk_w-1:0] c_stk_max  = c_stk_w'(STUCK_CYCLES);
`endif

  logic [2:0] raw_vec;
  logic [2:0] car_vec;

  assign raw_vec = {raw_ns, raw_lt, raw_ew};

  // Channel index doubles as the dir code that serves it (0=EW, 1=LT, 2=NS).
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic               s1_q, s2_q;
    logic               stable_q, stable_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               latch_q, latch_d;
    logic               car_q, car_d;
    logic               serve;
    logic               force_on;

`ifdef TLC_SENSOR_STUCK_EN
    logic [c_stk_w-1:0] stk_cnt_q, stk_cnt_d;
    logic               stuck_q, stuck_d;

    always_comb begin
      stk_cnt_d = '0;
      if (stable_q) begin
        stk_cnt_d = (stk_cnt_q == c_stk_max) ? stk_cnt_q : stk_cnt_q + c_stk_w'(1);
      end
      stuck_d = stable_q & (stuck_q | (stk_cnt_d == c_stk_max));
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        stk_cnt_q <= '0;
        stuck_q   <= 1'b0;
      end else begin
        stk_cnt_q <= stk_cnt_d;
        stuck_q   <= stuck_d;
      end
    end

    assign force_on = stuck_q;
    assign stuck[i] = stuck_q;
`else
    assign force_on = 1'b0;
`endif

    assign serve = ok && (dir == 2'(i));

    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (s2_q != stable_q) begin
        if (cnt_q == c_cnt_last) begin
          stable_d = ~stable_q;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      // A fresh detection outranks a serve landing on the same edge.
      latch_d = (stable_d & ~stable_q) | (latch_q & ~serve);
      car_d   = stable_q | latch_q | force_on;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
        latch_q  <= 1'b0;
        car_q    <= 1'b0;
      end else begin
        s1_q     <= raw_vec[i];
        s2_q     <= s1_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
        latch_q  <= latch_d;
        car_q    <= car_d;
      end
    end

    assign car_vec[i] = car_q;
  end

  assign car_ew = car_vec[0];
  assign car_lt = car_vec[1];
  assign car_ns = car_vec[2];

endmodule

`default_nettype wire

// File: tb/tb_tlc_sensor_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tlc_sensor_conditioner: directed + randomised bench with a            |
// | behavioural request model, checked every cycle.              Rev 1.0     |
// +--------------------------------------------------------------------------+

module tb_tlc_sensor_conditioner;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_ew, raw_lt, raw_ns;
  logic [1:0] dir;
  logic       ok;
  logic       car_ew, car_lt, car_ns;
`ifdef TLC_SENSOR_STUCK_EN
  logic [2:0] stuck;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  tlc_sensor_conditioner #(.DEB_CYCLES(DEB)) dut (
    .clk    (clk),
    .rst    (rst),
    .raw_ew (raw_ew),
    .raw_lt (raw_lt),
    .raw_ns (raw_ns),
    .dir    (dir),
    .ok     (ok),
    .car_ew (car_ew),
    .car_lt (car_lt),
    .car_ns (car_ns)
`ifdef TLC_SENSOR_STUCK_EN
    ,
    .stuck  (stuck)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: raw is seen two edges late; stable follows once DEB
  // consecutive late samples disagree; a rising stable is remembered until served.
  bit [2:0] m_s1, m_s2, m_stab, m_lat, m_car;
  int       m_run [3];

  always @(posedge clk) begin
    bit [2:0] raw_now;
    bit [2:0] old_stab;
    raw_now  = {raw_ns, raw_lt, raw_ew};
    old_stab = m_stab;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_lat = '0; m_car = '0;
      for (int c = 0; c < 3; c++) m_run[c] = 0;
    end else begin
      m_car = m_stab | m_lat;
      for (int c = 0; c < 3; c++) begin
        if (m_s2[c] != m_stab[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DEB) begin
            m_stab[c] = ~m_stab[c];
            m_run[c]  = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_stab[c] && !old_stab[c]) m_lat[c] = 1'b1;
        else if (ok && dir == 2'(c))   m_lat[c] = 1'b0;
      end
      m_s2 = m_s1;
      m_s1 = raw_now;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks = checks + 1;
      if ({car_ns, car_lt, car_ew} !== m_car) begin
        failures = failures + 1;
        $display("FAIL model_cmp t=%0t: car{ns,lt,ew} got %b expected %b", $time,
                 {car_ns, car_lt, car_ew}, m_car);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_bit(input string name, input logic got, input logic exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s t=%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic serve(input logic [1:0] d);
    dir = d; ok = 1'b1;
    tick(1);
    dir = 2'b11; ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1; raw_ew = 0; raw_lt = 0; raw_ns = 0; dir = 2'b11; ok = 0;
    tick(2);
    rst = 1'b0;
    chk_en = 1'b1;
    expect_bit("reset_ew", car_ew, 1'b0);
    tick(5);
    expect_bit("idle_all", car_ew | car_lt | car_ns, 1'b0);

    // EW latency and latch hold after the vehicle leaves
    raw_ew = 1'b1;
    tick(6);
    expect_bit("ew_edge6", car_ew, 1'b0);
    tick(1);
    expect_bit("ew_edge7", car_ew, 1'b1);
    tick(13);
    raw_ew = 1'b0;
    tick(10);
    expect_bit("ew_latched", car_ew, 1'b1);
    serve(2'b00);
    expect_bit("ew_serve_edge", car_ew, 1'b1);
    tick(1);
    expect_bit("ew_after_serve", car_ew, 1'b0);

    // NS glitch rejection, then a qualifying pulse
    raw_ns = 1'b1; tick(3); raw_ns = 1'b0;
    tick(10);
    expect_bit("ns_glitch3", car_ns, 1'b0);
    raw_ns = 1'b1; tick(5); raw_ns = 1'b0;
    tick(12);
    expect_bit("ns_pulse5", car_ns, 1'b1);
    serve(2'b10);
    tick(2);
    expect_bit("ns_served", car_ns, 1'b0);

    // LT: serve coincides with the debounce edge, set must win
    raw_lt = 1'b1;
    tick(5);
    dir = 2'b01; ok = 1'b1;
    tick(1);
    dir = 2'b11; ok = 1'b0; raw_lt = 1'b0;
    tick(12);
    expect_bit("lt_set_priority", car_lt, 1'b1);
    dir = 2'b11; ok = 1'b1;
    tick(2);
    ok = 1'b0;
    expect_bit("lt_dir11_noclear", car_lt, 1'b1);
    serve(2'b01);
    tick(2);
    expect_bit("lt_served", car_lt, 1'b0);

    // Reset discards a pending latch
    raw_ew = 1'b1; tick(10); raw_ew = 1'b0;
    tick(10);
    expect_bit("ew_latch_prerst", car_ew, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_bit("ew_rst_clear", car_ew, 1'b0);
    tick(5);
    expect_bit("ew_rst_stays0", car_ew, 1'b0);

    // All three channels at once
    {raw_ns, raw_lt, raw_ew} = 3'b111;
    tick(7);
    expect_bit("all_three", car_ew & car_lt & car_ns, 1'b1);
    {raw_ns, raw_lt, raw_ew} = 3'b000;
    tick(10);
    serve(2'b00); serve(2'b01); serve(2'b10);
    tick(2);
    expect_bit("all_served", car_ew | car_lt | car_ns, 1'b0);

    // Randomised stretch, checked by the model only
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) raw_ew = ~raw_ew;
      if ($urandom_range(0, 4) == 0) raw_lt = ~raw_lt;
      if ($urandom_range(0, 6) == 0) raw_ns = ~raw_ns;
      ok  = ($urandom_range(0, 3) == 0);
      dir = 2'($urandom_range(0, 3));
      if (k == 300) rst = 1'b1;
      if (k == 301) rst = 1'b0;
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
